// File: rtl/storage_chk_pkg.sv
// Shared types and widths for the storage response checker.
// Holds the FSM state enum, counter widths and a saturating increment.
package storage_chk_pkg;

    localparam int ERR_W       = 8;
    localparam int CNT_W       = 16;
    localparam int MAX_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Error counter increment that holds at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] err_sat_inc(
        input logic [ERR_W-1:0] v
    );
        if (v == {ERR_W{1'b1}}) begin
            return v;
        end
        return v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/d_delay_line.sv
// Shift register delaying the stimulus by DEPTH clock cycles.
// Ports: clk, reset (sync, active-high), d_in, d_out = d_in delayed DEPTH.
module d_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic d_out
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = d_in;
        for (int i = 1; i < int'(DEPTH); i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign d_out = sr_q[DEPTH-1];

endmodule

// File: rtl/storage_response_checker.sv
// Compares an element's observed output q_in against its stimulus d_in
// delayed by LATENCY cycles, counting compares and mismatches per run.
// Ports: clk, reset (sync, active-high), start/stop pulses, d_in, q_in;
//   busy (ARM/CHECK), done, pass (valid with done), err_count (saturating),
//   sample_count. Optional macro SRC_FIRST_ERR_EN adds first_err_idx,
//   first_err_exp and first_err_obs describing the run's first mismatch.
module storage_response_checker
    import storage_chk_pkg::*;
#(
    parameter int unsigned LATENCY     = 1,
    parameter logic [15:0] MAX_SAMPLES = 16'd1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             d_in,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
`ifdef SRC_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_exp,
    output logic             first_err_obs
`endif
);

    localparam int ARM_W = $clog2(MAX_LATENCY);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;

    logic             d_dly;
    logic             mismatch;
    logic [CNT_W-1:0] cnt_inc;
    logic [ERR_W-1:0] err_inc;

`ifdef SRC_FIRST_ERR_EN
    logic             fe_seen_q, fe_seen_d;
    logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
    logic             fe_exp_q, fe_exp_d;
    logic             fe_obs_q, fe_obs_d;
`endif

    // Runs continuously so the expected value is valid on the first compare.
    d_delay_line #(
        .DEPTH (LATENCY)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .d_out (d_dly)
    );

    assign mismatch = q_in ^ d_dly;
    assign cnt_inc  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign err_inc  = mismatch ? err_sat_inc(err_q) : err_q;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
`ifdef SRC_FIRST_ERR_EN
        fe_seen_d = fe_seen_q;
        fe_idx_d  = fe_idx_q;
        fe_exp_d  = fe_exp_q;
        fe_obs_d  = fe_obs_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_ARM;
                    arm_cnt_d = '0;
                    err_d     = '0;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
`ifdef SRC_FIRST_ERR_EN
                    fe_seen_d = 1'b0;
                    fe_idx_d  = '0;
                    fe_exp_d  = 1'b0;
                    fe_obs_d  = 1'b0;
`endif
                end
            end
            ST_ARM: begin
                if (stop) begin
                    // No compares yet, so this run cannot pass.
                    state_d = ST_DONE;
                    pass_d  = 1'b0;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    arm_cnt_d = arm_cnt_q + {{(ARM_W-1){1'b0}}, 1'b1};
                end
            end
            ST_CHECK: begin
                // The compare on a stop edge still counts.
                cnt_d = cnt_inc;
                err_d = err_inc;
`ifdef SRC_FIRST_ERR_EN
                if (mismatch && !fe_seen_q) begin
                    fe_seen_d = 1'b1;
                    fe_idx_d  = cnt_inc;
                    fe_exp_d  = d_dly;
                    fe_obs_d  = q_in;
                end
`endif
                if (stop || (cnt_inc == MAX_SAMPLES)) begin
                    state_d = ST_DONE;
                    pass_d  = (err_inc == '0) && (cnt_inc != '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            arm_cnt_q <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
`ifdef SRC_FIRST_ERR_EN
            fe_seen_q <= 1'b0;
            fe_idx_q  <= '0;
            fe_exp_q  <= 1'b0;
            fe_obs_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
`ifdef SRC_FIRST_ERR_EN
            fe_seen_q <= fe_seen_d;
            fe_idx_q  <= fe_idx_d;
            fe_exp_q  <= fe_exp_d;
            fe_obs_q  <= fe_obs_d;
`endif
        end
    end

    assign busy         = (state_q == ST_ARM) || (state_q == ST_CHECK);
    assign done         = (state_q == ST_DONE);
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign sample_count = cnt_q;

`ifdef SRC_FIRST_ERR_EN
    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_obs = fe_obs_q;
`endif

endmodule

// File: tb/tb_storage_response_checker.sv
// Scoreboard bench for storage_response_checker: two instances
// (LATENCY=1/default MAX, LATENCY=2/MAX=8) checked at each done rise.
module tb_storage_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, start_a, stop_a;
    logic reset_b, start_b, stop_b;
    logic d;
    logic q1, q2;
    logic qa, qb;
    int   mode;

    logic        busy_a, done_a, pass_a;
    logic [7:0]  err_a;
    logic [15:0] cnt_a;
    logic        busy_b, done_b, pass_b;
    logic [7:0]  err_b;
    logic [15:0] cnt_b;
`ifdef SRC_FIRST_ERR_EN
    logic [15:0] fe_idx_a, fe_idx_b;
    logic        fe_exp_a, fe_exp_b;
    logic        fe_obs_a, fe_obs_b;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct {
        bit p;
        int e;
        int c;
    } exp_t;

    exp_t qa_exp[$];
    exp_t qb_exp[$];

    // Element models: q1 = d registered once, q2 = d registered twice.
    always @(posedge clk) begin
        q1 <= d;
        q2 <= q1;
    end

    // mode 0: matching element, 1: stuck at 0, 2: inverted, 3: stuck at 0
    // with d driven directly by the test.
    assign qa = (mode == 0) ? q1 :
                (mode == 2) ? ~q1 : 1'b0;
    assign qb = q2;

    storage_response_checker #(
        .LATENCY     (1),
        .MAX_SAMPLES (16'd1000)
    ) dut_a (
        .clk          (clk),
        .reset        (reset_a),
        .start        (start_a),
        .stop         (stop_a),
        .d_in         (d),
        .q_in         (qa),
        .busy         (busy_a),
        .done         (done_a),
        .pass         (pass_a),
        .err_count    (err_a),
        .sample_count (cnt_a)
`ifdef SRC_FIRST_ERR_EN
        ,
        .first_err_idx (fe_idx_a),
        .first_err_exp (fe_exp_a),
        .first_err_obs (fe_obs_a)
`endif
    );

    storage_response_checker #(
        .LATENCY     (2),
        .MAX_SAMPLES (16'd8)
    ) dut_b (
        .clk          (clk),
        .reset        (reset_b),
        .start        (start_b),
        .stop         (stop_b),
        .d_in         (d),
        .q_in         (qb),
        .busy         (busy_b),
        .done         (done_b),
        .pass         (pass_b),
        .err_count    (err_b),
        .sample_count (cnt_b)
`ifdef SRC_FIRST_ERR_EN
        ,
        .first_err_idx (fe_idx_b),
        .first_err_exp (fe_exp_b),
        .first_err_obs (fe_obs_b)
`endif
    );

    task automatic chk(input string name, input int act, input int req);
        chk_cnt++;
        if (act == req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Stimulus driver for d (mode 1 toggles, mode 3 is test-driven).
    initial begin
        d = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 1) begin
                d = ~d;
            end else if (mode != 3) begin
                d = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitors: pop and compare on each rising edge of done.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_a && !prev) begin
                if (qa_exp.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    e = qa_exp.pop_front();
                    chk("a_pass", int'(pass_a), int'(e.p));
                    chk("a_err_count", int'(err_a), e.e);
                    chk("a_sample_count", int'(cnt_a), e.c);
                end
            end
            prev = done_a;
        end
    end

    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_b && !prev) begin
                if (qb_exp.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    e = qb_exp.pop_front();
                    chk("b_pass", int'(pass_b), int'(e.p));
                    chk("b_err_count", int'(err_b), e.e);
                    chk("b_sample_count", int'(cnt_b), e.c);
                end
            end
            prev = done_b;
        end
    end

    // Start, then stop in the ncmp-th CHECK cycle (ncmp=0: stop in ARM).
    task automatic run_a(input int md, input int ncmp, input bit ep,
                         input int ee, input int ec);
        exp_t e;
        e = '{ep, ee, ec};
        mode = md;
        qa_exp.push_back(e);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        chk("a_busy_after_start", int'(busy_a), 1);
        chk("a_done_after_start", int'(done_a), 0);
        repeat (ncmp) begin
            @(posedge clk);
            #1;
        end
        stop_a = 1'b1;
        @(posedge clk);
        #1;
        stop_a = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_b();
        exp_t e;
        int   n;
        bit   seen;
        e = '{1'b1, 0, 8};
        qb_exp.push_back(e);
        n    = 0;
        seen = 1'b0;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_b) begin
                seen = 1'b1;
                break;
            end
            if (busy_b) n++;
        end
        chk("b_done_seen", int'(seen), 1);
        chk("b_busy_cycles", n, 10);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, "_busy"}, int'(busy_a), 0);
        chk({tag, "_done"}, int'(done_a), 0);
        chk({tag, "_pass"}, int'(pass_a), 0);
        chk({tag, "_err"}, int'(err_a), 0);
        chk({tag, "_cnt"}, int'(cnt_a), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", chk_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        mode    = 0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        start_a = 1'b0;
        stop_a  = 1'b0;
        start_b = 1'b0;
        stop_b  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        check_idle_a("a_reset");
        chk("b_reset_busy", int'(busy_b), 0);
        chk("b_reset_done", int'(done_b), 0);
        chk("b_reset_cnt", int'(cnt_b), 0);

        // Matching element, stop after 20 compares.
        run_a(0, 20, 1'b1, 0, 20);

        // Stuck-at-0 against toggling stimulus: half the compares miss.
        run_a(1, 10, 1'b0, 5, 10);

        // stop in DONE is ignored.
        stop_a = 1'b1;
        @(posedge clk);
        #1;
        stop_a = 1'b0;
        @(posedge clk);
        #1;
        chk("a_done_hold_after_stop", int'(done_a), 1);
        chk("a_err_hold_after_stop", int'(err_a), 5);

        // LATENCY=2, end by MAX_SAMPLES=8.
        mode = 0;
        run_b();

        // Inverted element: err_count saturates at 255.
        run_a(2, 300, 1'b0, 255, 300);

        // stop during ARM: zero compares, no pass.
        run_a(0, 0, 1'b0, 0, 0);

        // Reset in the 5th CHECK cycle.
        mode    = 0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("a_cnt_before_reset", int'(cnt_a), 4);
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        check_idle_a("a_midrun_reset");
        run_a(0, 6, 1'b1, 0, 6);

`ifdef SRC_FIRST_ERR_EN
        // Single mismatch on compare 7: expected 1, observed 0.
        begin
            exp_t e;
            e = '{1'b0, 1, 10};
            qa_exp.push_back(e);
            mode    = 3;
            d       = 1'b0;
            start_a = 1'b1;
            @(posedge clk);
            #1;
            start_a = 1'b0;
            for (int c = 2; c <= 11; c++) begin
                @(posedge clk);
                #1;
                d = (c == 7);
                if (c == 11) stop_a = 1'b1;
            end
            @(posedge clk);
            #1;
            stop_a = 1'b0;
            chk("a_first_err_idx", int'(fe_idx_a), 7);
            chk("a_first_err_exp", int'(fe_exp_a), 1);
            chk("a_first_err_obs", int'(fe_obs_a), 0);
            repeat (3) @(posedge clk);
            #1;
            mode = 0;
        end
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("a_queue_drained", qa_exp.size(), 0);
        chk("b_queue_drained", qb_exp.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
